// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding logic: operand-select
// encodings, the scoreboard slot record and its producer-match helper.
package pipe_pkg;

  // Widest register index any pipeline variant uses; slot dst is stored at this width.
  localparam int MAX_AW = 8;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_WB    = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dst;
    logic              wen;
    logic              load;
  } sb_slot_t;

  localparam sb_slot_t NOP_SLOT = '{valid: 1'b0, dst: {MAX_AW{1'b0}}, wen: 1'b0, load: 1'b0};

  // True when the slot produces the value the consumer reads from src.
  // load_only narrows the hit to load producers (value not ready before WB).
  function automatic logic slot_match(input sb_slot_t          slot,
                                      input logic [MAX_AW-1:0] src,
                                      input logic              used,
                                      input logic              zero_hard,
                                      input logic              load_only);
    slot_match = slot.valid && slot.wen && (slot.dst == src) && used &&
                 !(zero_hard && (src == {MAX_AW{1'b0}})) &&
                 (!load_only || slot.load);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage instruction description towards the hazard unit, and the
// pipeline-register controls / operand selects coming back.
interface hazard_fwd_unit_if
  import pipe_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_src1_used;
  logic              id_src2_used;
  logic [REG_AW-1:0] id_dst;
  logic              id_wen;
  logic              id_is_load;
  logic              id_is_branch;
  logic              id_branch_taken;
  logic              stall;
  logic              idex_bubble;
  logic              ifid_flush;
  fwd_sel_t          fwd_ex_sel1;
  fwd_sel_t          fwd_ex_sel2;
  fwd_sel_t          fwd_id_sel1;
  fwd_sel_t          fwd_id_sel2;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dst,
           id_wen, id_is_load, id_is_branch, id_branch_taken,
    input  stall, idex_bubble, ifid_flush, fwd_ex_sel1, fwd_ex_sel2,
           fwd_id_sel1, fwd_id_sel2, stall_cycles
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dst,
           id_wen, id_is_load, id_is_branch, id_branch_taken,
    output stall, idex_bubble, ifid_flush, fwd_ex_sel1, fwd_ex_sel2,
           fwd_id_sel1, fwd_id_sel2, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Three-slot (EX/MEM/WB) record of in-flight destinations and the producer
// match bits the hazard unit needs for EX forwarding, ID forwarding and stalls.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW        = 3,
  parameter int ZERO_REG_HARD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              stall,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_is_load,
  output logic [1:0]        ex_mem_hit,   // EX operand i produced by MEM slot
  output logic [1:0]        ex_wb_hit,    // EX operand i produced by WB slot
  output logic              id_ex_any1,   // ID src1 produced by EX slot
  output logic [1:0]        id_ex_ld,     // ID operand i produced by a load in EX
  output logic [1:0]        id_mem_any,   // ID operand i produced by MEM slot
  output logic [1:0]        id_mem_ld,    // ID operand i produced by a load in MEM
  output logic [1:0]        id_wb_hit     // ID operand i produced by WB slot
);

  localparam logic ZH = (ZERO_REG_HARD != 0);

  sb_slot_t          ex_slot_r, mem_slot_r, wb_slot_r, id_slot_s;
  logic [MAX_AW-1:0] ex_src1_r, ex_src2_r, id_src1_x, id_src2_x;
  logic [1:0]        ex_used_r;

  assign id_src1_x = MAX_AW'(id_src1);
  assign id_src2_x = MAX_AW'(id_src2);
  assign id_slot_s = '{valid: 1'b1, dst: MAX_AW'(id_dst), wen: id_wen, load: id_is_load};

  // Advance the slots each cycle; a stalled or empty ID slot enters EX as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_slot_r  <= NOP_SLOT;
      mem_slot_r <= NOP_SLOT;
      wb_slot_r  <= NOP_SLOT;
      ex_src1_r  <= {MAX_AW{1'b0}};
      ex_src2_r  <= {MAX_AW{1'b0}};
      ex_used_r  <= 2'b00;
    end else begin
      wb_slot_r  <= mem_slot_r;
      mem_slot_r <= ex_slot_r;
      if (id_valid && !stall) begin
        ex_slot_r <= id_slot_s;
        ex_src1_r <= id_src1_x;
        ex_src2_r <= id_src2_x;
        ex_used_r <= {id_src2_used, id_src1_used};
      end else begin
        ex_slot_r <= NOP_SLOT;
        ex_src1_r <= {MAX_AW{1'b0}};
        ex_src2_r <= {MAX_AW{1'b0}};
        ex_used_r <= 2'b00;
      end
    end
  end

  assign ex_mem_hit[0] = slot_match(mem_slot_r, ex_src1_r, ex_used_r[0], ZH, 1'b0);
  assign ex_mem_hit[1] = slot_match(mem_slot_r, ex_src2_r, ex_used_r[1], ZH, 1'b0);
  assign ex_wb_hit[0]  = slot_match(wb_slot_r,  ex_src1_r, ex_used_r[0], ZH, 1'b0);
  assign ex_wb_hit[1]  = slot_match(wb_slot_r,  ex_src2_r, ex_used_r[1], ZH, 1'b0);

  assign id_ex_any1    = slot_match(ex_slot_r,  id_src1_x, id_src1_used, ZH, 1'b0);
  assign id_ex_ld[0]   = slot_match(ex_slot_r,  id_src1_x, id_src1_used, ZH, 1'b1);
  assign id_ex_ld[1]   = slot_match(ex_slot_r,  id_src2_x, id_src2_used, ZH, 1'b1);
  assign id_mem_any[0] = slot_match(mem_slot_r, id_src1_x, id_src1_used, ZH, 1'b0);
  assign id_mem_any[1] = slot_match(mem_slot_r, id_src2_x, id_src2_used, ZH, 1'b0);
  assign id_mem_ld[0]  = slot_match(mem_slot_r, id_src1_x, id_src1_used, ZH, 1'b1);
  assign id_mem_ld[1]  = slot_match(mem_slot_r, id_src2_x, id_src2_used, ZH, 1'b1);
  assign id_wb_hit[0]  = slot_match(wb_slot_r,  id_src1_x, id_src1_used, ZH, 1'b0);
  assign id_wb_hit[1]  = slot_match(wb_slot_r,  id_src2_x, id_src2_used, ZH, 1'b0);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller: load-use / branch-compare
// stalls, EX and ID operand forwarding, multi-cycle branch squash and a
// saturating stall-cycle counter.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW        = 3,
  parameter int FLUSH_CYCLES  = 1,
  parameter int ZERO_REG_HARD = 0,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_fwd_unit_if.slave  bus
);

  // The accepting cycle squashes one fetch itself; the counter covers the rest.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0]       ex_mem_hit_s, ex_wb_hit_s, id_ex_ld_s, id_mem_any_s, id_mem_ld_s, id_wb_hit_s;
  logic             id_ex_any1_s;
  logic             load_use_s, br_hazard_s, stall_s, accept_s;
  logic [1:0]       flush_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  fwd_sel_t         ex_sel_s [2];
  fwd_sel_t         id_sel_s [2];

  hazard_scoreboard #(.REG_AW(REG_AW), .ZERO_REG_HARD(ZERO_REG_HARD)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (bus.id_valid),
    .stall        (stall_s),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_src1_used (bus.id_src1_used),
    .id_src2_used (bus.id_src2_used),
    .id_dst       (bus.id_dst),
    .id_wen       (bus.id_wen),
    .id_is_load   (bus.id_is_load),
    .ex_mem_hit   (ex_mem_hit_s),
    .ex_wb_hit    (ex_wb_hit_s),
    .id_ex_any1   (id_ex_any1_s),
    .id_ex_ld     (id_ex_ld_s),
    .id_mem_any   (id_mem_any_s),
    .id_mem_ld    (id_mem_ld_s),
    .id_wb_hit    (id_wb_hit_s)
  );

  // A load result is not ready for the next instruction; a branch compares in ID,
  // so it waits for any EX producer and for a load still in MEM.
  assign load_use_s  = id_ex_ld_s[0] || id_ex_ld_s[1];
  assign br_hazard_s = bus.id_is_branch && (id_ex_any1_s || id_mem_ld_s[0]);
  assign stall_s     = bus.id_valid && (load_use_s || br_hazard_s);
  assign accept_s    = bus.id_valid && bus.id_branch_taken && !stall_s;

  // Operand-mux selects: youngest producer wins in EX; ID takes WB (same-cycle
  // regfile write) or, for branches only, a finished ALU result from MEM.
  always_comb begin
    ex_sel_s[0] = FWD_REG;
    ex_sel_s[1] = FWD_REG;
    id_sel_s[0] = FWD_REG;
    id_sel_s[1] = FWD_REG;
    for (int i = 0; i < 2; i++) begin
      if (ex_mem_hit_s[i]) begin
        ex_sel_s[i] = FWD_EXMEM;
      end else if (ex_wb_hit_s[i]) begin
        ex_sel_s[i] = FWD_WB;
      end else begin
        ex_sel_s[i] = FWD_REG;
      end
      if (id_wb_hit_s[i]) begin
        id_sel_s[i] = FWD_WB;
      end else if (bus.id_is_branch && id_mem_any_s[i] && !id_mem_ld_s[i]) begin
        id_sel_s[i] = FWD_EXMEM;
      end else begin
        id_sel_s[i] = FWD_REG;
      end
    end
  end

  // Remaining squash cycles after an accepted taken branch; a new branch reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_r <= 2'd0;
    end else if (accept_s) begin
      flush_cnt_r <= FLUSH_RELOAD;
    end else if (flush_cnt_r != 2'd0) begin
      flush_cnt_r <= flush_cnt_r - 2'd1;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.idex_bubble  = stall_s;
  assign bus.ifid_flush   = accept_s || (flush_cnt_r != 2'd0);
  assign bus.fwd_ex_sel1  = ex_sel_s[0];
  assign bus.fwd_ex_sel2  = ex_sel_s[1];
  assign bus.fwd_id_sel1  = id_sel_s[0];
  assign bus.fwd_id_sel2  = id_sel_s[1];
  assign bus.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench: two hazard units (FLUSH=1/ZRH=0/CNT16 and
// FLUSH=3/ZRH=1/CNT4) share one stimulus stream; an instruction-level model
// predicts every output each cycle, plus hand-computed directed checks.
module tb_hazard_fwd_unit;
  localparam int AW = 3;
  localparam int F    [2] = '{1, 3};
  localparam int Z    [2] = '{0, 1};
  localparam int CMAX [2] = '{65535, 15};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_v = 1'b0, t_u1 = 1'b0, t_u2 = 1'b0, t_wen = 1'b0, t_ld = 1'b0, t_br = 1'b0, t_tk = 1'b0;
  logic [AW-1:0] t_s1 = '0, t_s2 = '0, t_dst = '0;
  bit chk_on = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(16)) bus0 ();
  hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(4))  bus1 ();

  assign bus0.id_valid = t_v;        assign bus1.id_valid = t_v;
  assign bus0.id_src1 = t_s1;        assign bus1.id_src1 = t_s1;
  assign bus0.id_src2 = t_s2;        assign bus1.id_src2 = t_s2;
  assign bus0.id_src1_used = t_u1;   assign bus1.id_src1_used = t_u1;
  assign bus0.id_src2_used = t_u2;   assign bus1.id_src2_used = t_u2;
  assign bus0.id_dst = t_dst;        assign bus1.id_dst = t_dst;
  assign bus0.id_wen = t_wen;        assign bus1.id_wen = t_wen;
  assign bus0.id_is_load = t_ld;     assign bus1.id_is_load = t_ld;
  assign bus0.id_is_branch = t_br;   assign bus1.id_is_branch = t_br;
  assign bus0.id_branch_taken = t_tk; assign bus1.id_branch_taken = t_tk;

  hazard_fwd_unit #(.REG_AW(AW), .FLUSH_CYCLES(1), .ZERO_REG_HARD(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  hazard_fwd_unit #(.REG_AW(AW), .FLUSH_CYCLES(3), .ZERO_REG_HARD(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // ---------------- behavioural model ----------------
  typedef struct {bit v; int dst; bit wen; bit ld; int s1; int s2; bit u1; bit u2;} ins_t;
  typedef struct {int stall; int flush; int exs1; int exs2; int ids1; int ids2;} exp_t;

  ins_t pipe_m [2][3];   // per unit: instruction now in EX (0), MEM (1), WB (2)
  int   fl_left [2];     // squashed fetches still owed after the accepting cycle
  int   scnt [2];
  ins_t blank;

  function automatic bit hit(int k, ins_t p, int s, bit used, bit need_ld);
    return p.v && p.wen && (p.dst == s) && used && !(Z[k] != 0 && s == 0) && (!need_ld || p.ld);
  endfunction

  function automatic ins_t cur_ins();
    ins_t c;
    c.v = 1'b1; c.dst = int'(t_dst); c.wen = t_wen; c.ld = t_ld;
    c.s1 = int'(t_s1); c.s2 = int'(t_s2); c.u1 = t_u1; c.u2 = t_u2;
    return c;
  endfunction

  function automatic bit m_stall(int k);
    bit lu, bs;
    lu = hit(k, pipe_m[k][0], int'(t_s1), t_u1, 1'b1) || hit(k, pipe_m[k][0], int'(t_s2), t_u2, 1'b1);
    bs = t_br && (hit(k, pipe_m[k][0], int'(t_s1), t_u1, 1'b0) || hit(k, pipe_m[k][1], int'(t_s1), t_u1, 1'b1));
    return t_v && (lu || bs);
  endfunction

  function automatic int ex_sel(int k, int s, bit used);
    if (!pipe_m[k][0].v) return 0;
    if (hit(k, pipe_m[k][1], s, used, 1'b0)) return 1;
    if (hit(k, pipe_m[k][2], s, used, 1'b0)) return 2;
    return 0;
  endfunction

  function automatic int id_sel(int k, int s, bit used);
    if (hit(k, pipe_m[k][2], s, used, 1'b0)) return 2;
    if (t_br && hit(k, pipe_m[k][1], s, used, 1'b0) && !pipe_m[k][1].ld) return 1;
    return 0;
  endfunction

  function automatic exp_t predict(int k);
    exp_t r;
    r.stall = int'(m_stall(k));
    r.flush = int'((t_v && t_tk && !m_stall(k)) || fl_left[k] > 0);
    r.exs1  = ex_sel(k, pipe_m[k][0].s1, pipe_m[k][0].u1);
    r.exs2  = ex_sel(k, pipe_m[k][0].s2, pipe_m[k][0].u2);
    r.ids1  = id_sel(k, int'(t_s1), t_u1);
    r.ids2  = id_sel(k, int'(t_s2), t_u2);
    return r;
  endfunction

  // Model state advance: instructions age one stage per clock; reset empties all.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 3; a++) pipe_m[k][a] <= blank;
        fl_left[k] <= 0;
        scnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        pipe_m[k][2] <= pipe_m[k][1];
        pipe_m[k][1] <= pipe_m[k][0];
        pipe_m[k][0] <= (t_v && !m_stall(k)) ? cur_ins() : blank;
        if (t_v && t_tk && !m_stall(k)) fl_left[k] <= F[k] - 1;
        else if (fl_left[k] > 0) fl_left[k] <= fl_left[k] - 1;
        if (m_stall(k) && scnt[k] < CMAX[k]) scnt[k] <= scnt[k] + 1;
      end
    end
  end

  task automatic chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic cmp(int k);
    exp_t x;
    int a [8];
    x = predict(k);
    if (k == 0) begin
      a = '{int'(bus0.stall), int'(bus0.idex_bubble), int'(bus0.ifid_flush), int'(bus0.fwd_ex_sel1),
            int'(bus0.fwd_ex_sel2), int'(bus0.fwd_id_sel1), int'(bus0.fwd_id_sel2), int'(bus0.stall_cycles)};
    end else begin
      a = '{int'(bus1.stall), int'(bus1.idex_bubble), int'(bus1.ifid_flush), int'(bus1.fwd_ex_sel1),
            int'(bus1.fwd_ex_sel2), int'(bus1.fwd_id_sel1), int'(bus1.fwd_id_sel2), int'(bus1.stall_cycles)};
    end
    chk($sformatf("dut%0d stall", k), a[0], x.stall);
    chk($sformatf("dut%0d idex_bubble", k), a[1], x.stall);
    chk($sformatf("dut%0d ifid_flush", k), a[2], x.flush);
    chk($sformatf("dut%0d fwd_ex_sel1", k), a[3], x.exs1);
    chk($sformatf("dut%0d fwd_ex_sel2", k), a[4], x.exs2);
    chk($sformatf("dut%0d fwd_id_sel1", k), a[5], x.ids1);
    chk($sformatf("dut%0d fwd_id_sel2", k), a[6], x.ids2);
    chk($sformatf("dut%0d stall_cycles", k), a[7], scnt[k]);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0);
      cmp(1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(bit iv, int is1, int is2, bit iu1, bit iu2, int idst, bit iwen, bit ild, bit ibr, bit itk);
    @(posedge clk); #1;
    t_v = iv; t_s1 = AW'(is1); t_s2 = AW'(is2); t_u1 = iu1; t_u2 = iu2;
    t_dst = AW'(idst); t_wen = iwen; t_ld = ild; t_br = ibr; t_tk = itk;
    @(negedge clk);
  endtask

  task automatic nop();             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(int d, int a, int b); drive(1, a, b, 1, 1, d, 1, 0, 0, 0); endtask
  task automatic load(int d, int a); drive(1, a, 0, 1, 0, d, 1, 1, 0, 0); endtask
  task automatic brn(int a, bit tk); drive(1, a, 0, 1, 0, 0, 0, 0, 1, tk); endtask
  task automatic drain();           repeat (3) nop(); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset stall", int'(bus0.stall), 0);
    chk("reset flush", int'(bus1.ifid_flush), 0);
    chk("reset stall_cycles", int'(bus0.stall_cycles), 0);

    // ALU -> ALU back-to-back: MEM forward, no stall
    alu(1, 5, 6);
    alu(2, 1, 1);
    chk("t1 no stall", int'(bus0.stall), 0);
    nop();
    chk("t1 ex_sel1", int'(bus0.fwd_ex_sel1), 1);
    chk("t1 ex_sel2", int'(bus0.fwd_ex_sel2), 1);

    // load-use: one stall, then WB forward
    drain();
    load(3, 7);
    alu(4, 3, 5);
    chk("t2 stall", int'(bus0.stall), 1);
    chk("t2 bubble", int'(bus0.idex_bubble), 1);
    alu(4, 3, 5);
    chk("t2 released", int'(bus0.stall), 0);
    nop();
    chk("t2 ex_sel1", int'(bus0.fwd_ex_sel1), 2);
    chk("t2 ex_sel2", int'(bus0.fwd_ex_sel2), 0);
    chk("t2 stall_cycles", int'(bus0.stall_cycles), 1);

    // WB -> ID same-cycle forward
    drain();
    alu(2, 5, 6);
    nop();
    nop();
    alu(6, 2, 7);
    chk("t3 id_sel1", int'(bus0.fwd_id_sel1), 2);

    // ALU -> branch: one stall (no flush), then MEM->ID forward and flush
    drain();
    alu(1, 5, 6);
    brn(1, 1'b1);
    chk("t4 stall", int'(bus0.stall), 1);
    chk("t4 stall wins f1", int'(bus0.ifid_flush), 0);
    chk("t4 stall wins f3", int'(bus1.ifid_flush), 0);
    brn(1, 1'b1);
    chk("t4 id_sel1", int'(bus0.fwd_id_sel1), 1);
    chk("t4 flush f1 c0", int'(bus0.ifid_flush), 1);
    chk("t4 flush f3 c0", int'(bus1.ifid_flush), 1);
    nop();
    chk("t4 flush f1 c1", int'(bus0.ifid_flush), 0);
    chk("t4 flush f3 c1", int'(bus1.ifid_flush), 1);
    nop();
    chk("t4 flush f3 c2", int'(bus1.ifid_flush), 1);
    nop();
    chk("t4 flush f3 c3", int'(bus1.ifid_flush), 0);

    // r0 producer: forwarded only when the zero register is not hardwired
    drain();
    alu(0, 5, 6);
    alu(7, 0, 0);
    chk("t5 zrh0 stall", int'(bus0.stall), 0);
    chk("t5 zrh1 stall", int'(bus1.stall), 0);
    nop();
    chk("t5 zrh0 ex_sel1", int'(bus0.fwd_ex_sel1), 1);
    chk("t5 zrh1 ex_sel1", int'(bus1.fwd_ex_sel1), 0);
    chk("t5 zrh1 ex_sel2", int'(bus1.fwd_ex_sel2), 0);

    // reset in the middle of a 3-cycle flush
    drain();
    brn(5, 1'b1);
    chk("t6 flush start", int'(bus1.ifid_flush), 1);
    nop();
    chk("t6 flush mid", int'(bus1.ifid_flush), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6 async flush clear", int'(bus1.ifid_flush), 0);
    chk("t6 async cnt clear 1", int'(bus1.stall_cycles), 0);
    chk("t6 async cnt clear 0", int'(bus0.stall_cycles), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6 after release", int'(bus1.ifid_flush), 0);

    // 20 load-use stalls: 4-bit counter saturates, 16-bit counter does not
    repeat (20) begin
      load(3, 7);
      alu(4, 3, 5);
      alu(4, 3, 5);
    end
    nop();
    chk("sat cnt4", int'(bus1.stall_cycles), 15);
    chk("sat cnt16", int'(bus0.stall_cycles), 20);

    // randomized traffic over a small register file
    repeat (3000) begin
      @(posedge clk); #1;
      t_v   = ($urandom_range(0, 9) < 8);
      t_s1  = AW'($urandom_range(0, 7));
      t_s2  = AW'($urandom_range(0, 7));
      t_u1  = ($urandom_range(0, 3) != 0);
      t_u2  = ($urandom_range(0, 1) != 0);
      t_dst = AW'($urandom_range(0, 7));
      t_wen = ($urandom_range(0, 3) != 0);
      t_ld  = t_wen && ($urandom_range(0, 2) == 0);
      t_br  = ($urandom_range(0, 3) == 0);
      t_tk  = t_br && ($urandom_range(0, 1) == 1);
    end
    drain();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard detection and forwarding controller for the in-order IF/ID/EX/MEM/WB pipeline. It replaces the current branch-squash-only scheme (which zeroes the fetched word on `pc_sel`) with four mechanisms:
- an internal scoreboard of in-flight destinations;
- operand forwarding into both EX and ID;
- a one-cycle load-use stall;
- a configurable multi-cycle branch flush.

It sits beside the pipeline registers and drives their hold/flush/bubble controls and the operand-mux selects.

## Interface
Parameters:
- `REG_AW`, 3: register index width.
- `FLUSH_CYCLES`, 1: IF/ID squash cycles per taken branch. Legal range 1..3.
- `ZERO_REG_HARD`, 0: when 1, destination index 0 never causes a forward or stall.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous active-high reset.
- `id_valid` in 1: ID holds a real instruction. Upstream clears it for squashed slots.
- `id_src1`, `id_src2` in REG_AW: source indices read in ID.
- `id_src1_used`, `id_src2_used` in 1: the corresponding source is actually consumed.
- `id_dst` in REG_AW: destination index of the ID instruction.
- `id_wen` in 1: the ID instruction writes the register file.
- `id_is_load` in 1: the ID instruction is a load (mem_to_reg).
- `id_is_branch` in 1: the ID instruction is a branch that compares `id_src1` in ID.
- `id_branch_taken` in 1: the branch resolved taken this cycle (pc_sel).
- `stall` out 1: hold PC and IF/ID.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `ifid_flush` out 1: squash the word entering IF/ID.
- `fwd_ex_sel1`, `fwd_ex_sel2` out 2: EX operand select. 0 = ID/EX register, 1 = EX/MEM ALU result, 2 = write-back data.
- `fwd_id_sel1`, `fwd_id_sel2` out 2: ID operand select with the same encoding.
- `stall_cycles` out CNT_W: saturating count of stall cycles.

## Operation
Scoreboard:
- Three slots, EX, MEM and WB. Each holds {valid, dst, wen, load}.
- The EX slot also holds src1/src2 and their used flags.
- Every cycle: WB←MEM and MEM←EX.
- EX←ID instruction when `id_valid` and not `stall`; otherwise EX←invalid.

Match rule: a slot matches source `s` when all of the following hold:
- slot.valid && slot.wen;
- slot.dst == s;
- the source's used flag is set;
- !(ZERO_REG_HARD && s == 0).

EX forwarding (per operand):
- MEM-slot match → 1.
- Otherwise WB-slot match → 2.
- Otherwise → 0.
- MEM has priority over WB (youngest producer wins).

ID forwarding (per operand):
- WB-slot match → 2. This covers same-cycle regfile write/read.
- Non-load MEM-slot match with `id_is_branch` → 1.
- Otherwise → 0.

Stall conditions (`id_valid` required):
- Load-use: the EX slot is a load and matches either ID source.
- Branch compare: `id_is_branch` and either of these:
  - EX slot matches `id_src1` (any producer);
  - MEM slot is a load matching `id_src1`.

When `stall` is high:
- `idex_bubble` = 1.
- The branch is not accepted; ID re-evaluates next cycle.

Branch flush:
- A branch is accepted when `id_valid && id_branch_taken && !stall`.
- On acceptance, `ifid_flush` = 1 combinationally and `flush_cnt` ← FLUSH_CYCLES−1.
- While `flush_cnt` ≠ 0: `ifid_flush` = 1, and the counter decrements.
- A new acceptance reloads the counter.

Counter: `stall_cycles` increments on each stall cycle and holds at all-ones.

## Timing
- Reset (async, immediate): all slots invalid, `flush_cnt` = 0, `stall_cycles` = 0.
  - As a result all outputs are 0 and all selects are 0.
- Selects, `stall`, `idex_bubble` and `ifid_flush` are combinational from the inputs and the registered slots. There is no added latency.
- Load-use costs exactly 1 stall cycle. The consumer then reaches EX with sel = 2.
- ALU-to-ALU back-to-back costs 0 stall cycles (sel = 1).
- A taken branch costs FLUSH_CYCLES squashed fetches.
- Stall and taken branch in the same cycle: stall wins and no flush is issued.
- Reset asserted mid-stall or mid-flush clears everything on the edge. The first cycle after release sees an empty pipeline.

## Structure
- `pipe_pkg` holds:
  - `fwd_sel_t` encodings (FWD_REG=0, FWD_EXMEM=1, FWD_WB=2);
  - the `sb_slot_t` struct {valid, dst, wen, load};
  - `NOP_SLOT`.
- One sub-module, `hazard_scoreboard`, implements the three-slot shift and the match functions.
- The top level adds the stall/forward priority logic, the flush counter and the stall counter.

## Test plan
1. `add r1` then `add r2,r1,r1` back-to-back → cycle 2: `fwd_ex_sel1` = `fwd_ex_sel2` = 1, `stall` = 0.
2. `ld r3` then `sub r4,r3,r5` → exactly one cycle with `stall` = `idex_bubble` = 1, then `fwd_ex_sel1` = 2. `stall_cycles` = 1.
3. `add r2`, nop, nop, then `or r6,r2` in ID while the add is in WB → `fwd_id_sel1` = 2.
4. `add r1` followed by `beq r1` → 1 stall. Then `fwd_id_sel1` = 1, then taken: `ifid_flush` high for FLUSH_CYCLES (test FLUSH_CYCLES = 1 and 3).
5. ZERO_REG_HARD = 1 with `add r0` followed by use of r0 → all selects 0, no stall. With ZERO_REG_HARD = 0 → `fwd_ex_sel1` = 1.
6. Assert `rst` mid-flush with FLUSH_CYCLES = 3 → `ifid_flush` drops immediately and `stall_cycles` = 0. Saturation test: preload CNT_W = 4 with 20 stalls → count holds at 15.
